ahb_cmd_master: RTL
===================

// Module: ahb_cmd_master
// PURPOSE
//  Reader end of the AHB transaction queue: pops queued commands {write, size, addr, data}
//  and drives them as AHB-Lite SINGLE transfers.
//  Pipelined master: address phase of cmd N+1 overlaps data phase of cmd N.
//  Returns one in-order response per command (read data / error) to the testbench/scoreboard.
//  Sits between the transaction FIFO (cmd side) and the AHB-Lite slave/decoder (bus side).
// PARAMETERS
//  BUS_WIDTH   `BUS_WIDTH (32)   HADDR/HWDATA/HRDATA and cmd addr/data width
// PORTS
//  clk         in   1          bus clock, all logic on posedge
//  resetn      in   1          synchronous, active-low reset
//  cmd_valid   in   1          command available at queue head
//  cmd_ready   out  1          command consumed this cycle when cmd_valid&cmd_ready
//  cmd_write   in   1          1=write, 0=read
//  cmd_size    in   3          HSIZE encoding
//  cmd_addr    in   BUS_WIDTH  transfer address
//  cmd_wdata   in   BUS_WIDTH  write data, already on correct byte lanes
//  rsp_valid   out  1          one-cycle pulse per completed command
//  rsp_write   out  1          echo of command direction
//  rsp_err     out  1          1 = ERROR response (or rejected, see CONFIGURATION)
//  rsp_rdata   out  BUS_WIDTH  HRDATA for reads, 0 for writes/errors
//  HADDR HWRITE HSIZE[2:0] HBURST[2:0] HTRANS[1:0] HPROT[3:0] HMASTLOCK HWDATA  out  AHB master
//  HRDATA HREADY HRESP        in   AHB slave return
// BEHAVIOUR
//  - Two register slots: A (address phase) and D (data phase), each valid bit + cmd fields.
//  - Outputs registered: HADDR/HWRITE/HSIZE from slot A; HWDATA from slot D (0 if D empty).
//  - HTRANS = NONSEQ(2'b10) when A valid and not suppressed, else IDLE(2'b00); never BUSY/SEQ.
//  - Constants: HBURST=3'b000, HPROT=4'b0011, HMASTLOCK=0.
//  - cmd_ready = !A_valid | (HREADY & !err_first); combinational.
//  - On posedge with HREADY=1: D <= A (or D_valid<=0 if A empty); A <= cmd if handshake else
//    A_valid<=0. With HREADY=0: A and D hold; A's fields never change while HREADY low.
//  - Response: when D_valid & HREADY=1 -> rsp_valid=1 next cycle, rsp_err=HRESP,
//    rsp_rdata = (!write & !HRESP) ? HRDATA : 0. Responses strictly in command order.
//  - Latency: idle bus, zero-wait slave: cmd accepted cycle 0, NONSEQ cycle 1, data phase
//    cycle 2, rsp_valid cycle 3. Back-to-back throughput 1 cmd/cycle.
//  - ERROR (two-cycle): cycle with HRESP=1,HREADY=0 sets err_first; HTRANS forced IDLE that
//    cycle and the next, slot A retained (not dropped) and re-issued as NONSEQ after the error
//    completes. Error cycle 2 (HRESP=1,HREADY=1) retires D with rsp_err=1.
//  - Wait states unbounded; no timeout.
//  - Reset (resetn=0 at posedge): A_valid=D_valid=0, err_first=0, HTRANS=IDLE, HADDR=0,
//    HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_write=0.
//    In-flight commands dropped, no responses issued for them; cmd_ready=0 during reset.
//  - cmd_size > log2(BUS_WIDTH/8) is driven as given (slave's problem) unless ALIGN check on.
// CONFIGURATION
//  AHB_MASTER_ALIGN_CHECK_EN defined: command in slot A with addr not aligned to 2^size, or size
//    wider than bus, is a bubble: HTRANS=IDLE for its address phase, passes to D as
//    normal, retires with rsp_err=1, rsp_rdata=0 when D advances; ordering preserved.
//  Not defined: no check, every command issued as NONSEQ.
// TESTING
//  1 single write: cmd{w=1,size=2,addr=0x10,data=0xDEADBEEF}, HREADY=1 -> NONSEQ cyc1,
//    HWDATA=0xDEADBEEF cyc2, rsp_valid cyc3 err=0 rdata=0.
//  2 back-to-back: 4 reads addr 0x0,0x4,0x8,0xC, HRDATA=addr+0x100 -> 4 consecutive NONSEQ,
//    rsp_rdata 0x100,0x104,0x108,0x10C in order on 4 consecutive cycles.
//  3 wait states: HREADY=0 for 3 cycles during write data phase -> HADDR/HTRANS of next cmd
//    and HWDATA stable all 3 cycles, cmd_ready=0, single rsp after HREADY returns.
//  4 error: read 0x20 gets HRESP=1 two cycles -> HTRANS IDLE both cycles, rsp_err=1
//    rdata=0; following write 0x24 re-issued NONSEQ and completes err=0.
//  5 reset mid-op: resetn=0 while 2 cmds in flight -> next cycle HTRANS=IDLE, HADDR=0,
//    no rsp_valid for dropped cmds; new cmd after reset completes normally.
//  6 ALIGN_CHECK_EN: cmd{size=2,addr=0x13} -> no NONSEQ, rsp_err=1; without macro NONSEQ addr 0x13.

Source files
------------

// File: rtl/ahb_cmd_master_if.sv
// ahb_cmd_master_if: command queue, response and AHB-Lite master signals for ahb_cmd_master.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
interface ahb_cmd_master_if #(parameter int BUS_WIDTH = `BUS_WIDTH);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [2:0]           cmd_size;
   logic [BUS_WIDTH-1:0] cmd_addr;
   logic [BUS_WIDTH-1:0] cmd_wdata;
   logic                 rsp_valid;
   logic                 rsp_write;
   logic                 rsp_err;
   logic [BUS_WIDTH-1:0] rsp_rdata;
   logic [BUS_WIDTH-1:0] HADDR;
   logic                 HWRITE;
   logic [2:0]           HSIZE;
   logic [2:0]           HBURST;
   logic [1:0]           HTRANS;
   logic [3:0]           HPROT;
   logic                 HMASTLOCK;
   logic [BUS_WIDTH-1:0] HWDATA;
   logic [BUS_WIDTH-1:0] HRDATA;
   logic                 HREADY;
   logic                 HRESP;
   modport master (
      input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
      output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
             HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK, HWDATA
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
      input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
             HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK, HWDATA
   );
endinterface

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: pops queued commands and drives them as pipelined AHB-Lite SINGLE transfers.
// Define AHB_MASTER_ALIGN_CHECK_EN to turn misaligned/oversized commands into erroring IDLE bubbles.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
module ahb_cmd_master #(parameter int BUS_WIDTH = `BUS_WIDTH) (
   input logic clk,
   input logic resetn,
   ahb_cmd_master_if.master bus
);
   logic                 a_valid, a_write, a_bad;
   logic [2:0]           a_size;
   logic [BUS_WIDTH-1:0] a_addr, a_wdata;
   logic                 d_valid, d_write, d_bad;
   logic [BUS_WIDTH-1:0] d_wdata;
   logic                 err_first, take, retire;
   logic                 rsp_valid, rsp_write, rsp_err;
   logic [BUS_WIDTH-1:0] rsp_rdata;
`ifdef AHB_MASTER_ALIGN_CHECK_EN
   localparam logic [2:0] MAX_SIZE = 3'($clog2(BUS_WIDTH/8));
   assign a_bad = (a_size > MAX_SIZE) | (|(a_addr & ~({BUS_WIDTH{1'b1}} << a_size)));
`else
   assign a_bad = 1'b0;
`endif
   assign bus.cmd_ready = resetn & (~a_valid | (bus.HREADY & ~err_first));
   assign take          = bus.cmd_valid & bus.cmd_ready;
   assign retire        = d_valid & bus.HREADY;
   // Both error cycles go IDLE; the first one is seen combinationally from HRESP.
   assign bus.HTRANS    = (a_valid & ~a_bad & ~err_first & ~(bus.HRESP & ~bus.HREADY)) ? 2'b10 : 2'b00;
   assign bus.HADDR     = a_addr;
   assign bus.HWRITE    = a_write;
   assign bus.HSIZE     = a_size;
   assign bus.HWDATA    = d_wdata;
   assign bus.HBURST    = 3'b000;
   assign bus.HPROT     = 4'b0011;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_write = rsp_write;
   assign bus.rsp_err   = rsp_err;
   assign bus.rsp_rdata = rsp_rdata;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_valid   <= 1'b0;
         a_write   <= 1'b0;
         a_size    <= '0;
         a_addr    <= '0;
         a_wdata   <= '0;
         d_valid   <= 1'b0;
         d_write   <= 1'b0;
         d_bad     <= 1'b0;
         d_wdata   <= '0;
         err_first <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (bus.HREADY) begin
            // After an error the address phase was IDLE, so slot A stays put and D empties.
            d_valid   <= a_valid & ~err_first;
            d_write   <= a_write;
            d_bad     <= a_bad;
            d_wdata   <= (a_valid & ~err_first) ? a_wdata : '0;
            err_first <= 1'b0;
         end else if (bus.HRESP) begin
            err_first <= 1'b1;
         end
         if (take) begin
            a_valid <= 1'b1;
            a_write <= bus.cmd_write;
            a_size  <= bus.cmd_size;
            a_addr  <= bus.cmd_addr;
            a_wdata <= bus.cmd_wdata;
         end else if (bus.HREADY & ~err_first) begin
            a_valid <= 1'b0;
         end
         rsp_valid <= retire;
         rsp_write <= retire & d_write;
         rsp_err   <= retire & (bus.HRESP | d_bad);
         rsp_rdata <= (retire & ~d_write & ~bus.HRESP & ~d_bad) ? bus.HRDATA : '0;
      end
   end
endmodule
